// File: rtl/bfp_pkg.sv
// Shared types and width helpers for the block-floating-point mantissa aligner.
package bfp_pkg;

  typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_e;

  function automatic int exp_w(input int bit_w, input int fpm);
    return bit_w - fpm - 1;
  endfunction

  function automatic int exp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Unbiased image of the biased all-zero exponent (the encoding used for +/-0).
  function automatic int zero_exp(input int ew);
    return -exp_bias(ew);
  endfunction

  // Exponent difference needs one extra bit so a larger element exponent shows as negative.
  function automatic int shift_w(input int ew);
    return ew + 1;
  endfunction

endpackage

// File: rtl/bfp_align_lane.sv
// Combinational single-element alignment to the shared exponent.
// Optional half-up rounding with BFP_MANT_ALIGN_ROUND_EN.
module bfp_align_lane
  import bfp_pkg::*;
#(
  parameter int BIT = 32,
  parameter int FPM = 23,
  parameter int MW  = 16,
  localparam int EW = exp_w(BIT, FPM),
  localparam int SW = shift_w(EW)
) (
  input  logic [BIT-1:0] i_elem,
  input  logic [EW-1:0]  i_exp,
  output logic [MW-1:0]  o_mant,
  output logic           o_err
);

`ifdef BFP_MANT_ALIGN_ROUND_EN
  localparam int L = MW;      // keeps one extra bit below the kept magnitude for rounding
`else
  localparam int L = MW - 1;
`endif

  localparam logic [EW-1:0] ZEXP = EW'(zero_exp(EW));

  logic           w_sign;
  logic [EW-1:0]  w_eexp;
  logic [FPM-1:0] w_frac;
  logic [SW-1:0]  w_diff;
  logic [SW-1:0]  w_shift;
  logic [L-1:0]   w_ext;
  logic [L-1:0]   w_sh;
  logic [MW-2:0]  w_mag;
  logic [MW-2:0]  w_mag_z;
  logic           w_zero;

  assign w_sign = i_elem[BIT-1];
  assign w_eexp = i_elem[BIT-2:FPM];
  assign w_frac = i_elem[FPM-1:0];

  assign w_diff  = {i_exp[EW-1], i_exp} - {w_eexp[EW-1], w_eexp};
  assign o_err   = w_diff[SW-1];
  assign w_shift = o_err ? '0 : w_diff;

  if (FPM + 1 >= L) begin : g_trunc
    assign w_ext = {1'b1, w_frac[FPM-1 -: L-1]};
  end else begin : g_pad
    assign w_ext = {1'b1, w_frac, {(L-FPM-1){1'b0}}};
  end

  // Shifts of L or more drain every bit, so no explicit clamp is needed.
  assign w_sh = w_ext >> w_shift;

`ifdef BFP_MANT_ALIGN_ROUND_EN
  logic [MW-1:0] w_sum;
  assign w_sum = {1'b0, w_sh[L-1:1]} + {{(MW-1){1'b0}}, w_sh[0]};
  assign w_mag = w_sum[MW-1] ? '1 : w_sum[MW-2:0];
`else
  assign w_mag = w_sh;
`endif

  assign w_zero  = (w_eexp == ZEXP) && (w_frac == '0);
  assign w_mag_z = w_zero ? '0 : w_mag;
  assign o_mant  = w_sign ? -{1'b0, w_mag_z} : {1'b0, w_mag_z};

endmodule

// File: rtl/bfp_mant_align.sv
// Latches a vector plus shared exponent and streams aligned signed mantissas P per beat.
// Rounding option: BFP_MANT_ALIGN_ROUND_EN (see bfp_align_lane).
module bfp_mant_align
  import bfp_pkg::*;
#(
  parameter int V   = 8,
  parameter int P   = 4,
  parameter int BIT = 32,
  parameter int FPM = 23,
  parameter int MW  = 16,
  localparam int EW = exp_w(BIT, FPM),
  localparam int IW = $clog2(V)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [V*BIT-1:0] invect,
  input  logic [EW-1:0]   inExp,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [P*MW-1:0] out_mants,
  output logic [IW-1:0]   out_idx,
  output logic [EW-1:0]   out_exp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            done,
  output logic            align_err
);

  state_e                   r_state, w_nxt;
  logic                     r_armed, w_nxt_armed;
  logic                     r_in_ready;
  logic [V-1:0][BIT-1:0]    r_vec;
  logic [EW-1:0]            r_exp;
  logic [IW-1:0]            r_idx;
  logic                     r_err;
  logic                     w_acc, w_xfer, w_last;
  logic [P-1:0][MW-1:0]     w_mant;
  logic [P-1:0]             w_err;

  assign w_acc  = (r_state == IDLE) && r_in_ready && in_valid;
  assign w_xfer = (r_state == ALIGN) && out_ready;
  assign w_last = (r_idx == IW'(V - P));

  always_comb begin
    w_nxt       = r_state;
    w_nxt_armed = r_armed;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_nxt       = ALIGN;
          w_nxt_armed = 1'b0;
        end else if (!in_valid) begin
          w_nxt_armed = 1'b1;
        end
      end
      ALIGN:   if (w_xfer && w_last) w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // in_ready is registered so it reads low for the reset cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_armed    <= 1'b1;
      r_in_ready <= 1'b0;
      r_vec      <= '0;
      r_exp      <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_armed    <= w_nxt_armed;
      r_in_ready <= (w_nxt == IDLE) && w_nxt_armed;
      if (w_acc) begin
        r_vec <= invect;
        r_exp <= inExp;
        r_idx <= '0;
      end
      if (w_xfer) r_idx <= w_last ? '0 : r_idx + IW'(P);
      if ((r_state == ALIGN) && |w_err) r_err <= 1'b1;
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    bfp_align_lane #(.BIT(BIT), .FPM(FPM), .MW(MW)) u_lane (
      .i_elem (r_vec[r_idx + IW'(j)]),
      .i_exp  (r_exp),
      .o_mant (w_mant[j]),
      .o_err  (w_err[j])
    );
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == ALIGN);
  assign done      = (r_state == DONE);
  assign out_mants = out_valid ? w_mant : '0;
  assign out_idx   = r_idx;
  assign out_exp   = r_exp;
  assign align_err = r_err;

endmodule

// File: tb/tb_bfp_mant_align.sv
// Self-checking bench for bfp_mant_align: directed cases plus random vectors vs an arithmetic model.
module tb_bfp_mant_align;

  localparam int V = 8, P = 4, BIT = 32, FPM = 23, MW = 16, EW = 8, IW = 3;
  localparam int NB = V / P;

  logic             clk = 1'b0;
  logic             reset;
  logic [V*BIT-1:0] invect;
  logic [EW-1:0]    inExp;
  logic             in_valid;
  logic             in_ready;
  logic [P*MW-1:0]  out_mants;
  logic [IW-1:0]    out_idx;
  logic [EW-1:0]    out_exp;
  logic             out_valid;
  logic             out_ready;
  logic             done;
  logic             align_err;

  int errors = 0;
  int checks = 0;
  logic [P*MW-1:0] first_beat;

  bfp_mant_align #(.V(V), .P(P), .BIT(BIT), .FPM(FPM), .MW(MW)) dut (
    .clk(clk), .reset(reset), .invect(invect), .inExp(inExp), .in_valid(in_valid),
    .in_ready(in_ready), .out_mants(out_mants), .out_idx(out_idx), .out_exp(out_exp),
    .out_valid(out_valid), .out_ready(out_ready), .done(done), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [BIT-1:0] mk(input logic s, input int e, input int f);
    logic [EW-1:0]  ev;
    logic [FPM-1:0] fv;
    ev = EW'(e);
    fv = FPM'(f);
    return {s, ev, fv};
  endfunction

  // Value-level model: aligned magnitude = floor(({1,frac}) / 2^(FPM+1-(MW-1)+shift)).
  function automatic logic [MW-1:0] ref_mant(input logic [BIT-1:0] e, input logic [EW-1:0] ie);
    int     ex, ix, sh, k;
    longint full, mag, lim;
    logic [MW-1:0] r;
    ex   = int'($signed(e[BIT-2:FPM]));
    ix   = int'($signed(ie));
    full = (longint'(1) << FPM) + longint'(e[FPM-1:0]);
    if (ex == -((1 << (EW-1)) - 1) && e[FPM-1:0] == 0) return '0;
    sh = ix - ex;
    if (sh < 0) sh = 0;
    k   = FPM + 1 - (MW - 1) + sh;
    lim = (longint'(1) << (MW-1)) - 1;
`ifdef BFP_MANT_ALIGN_ROUND_EN
    mag = (k > 40) ? 0 : (full + (longint'(1) << (k-1))) >> k;
    if (mag > lim) mag = lim;
`else
    mag = (k > 40) ? 0 : full >> k;
`endif
    r = MW'(mag);
    return e[BIT-1] ? MW'(-mag) : r;
  endfunction

  function automatic logic [P*MW-1:0] ref_beat(input logic [V*BIT-1:0] vec,
                                               input logic [EW-1:0] ie, input int b);
    logic [P*MW-1:0] r;
    for (int j = 0; j < P; j++) r[j*MW +: MW] = ref_mant(vec[(b*P+j)*BIT +: BIT], ie);
    return r;
  endfunction

  // Present one vector, stream every beat (optional stall), then check the done pulse.
  task automatic run_vec(input string tag, input logic [V*BIT-1:0] vec, input logic [EW-1:0] ie,
                         input int stall_beat, input int stall_len, input logic drop_valid);
    int n, beat, stalled, cyc;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    invect = vec; inExp = ie; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    if (drop_valid) in_valid = 1'b0;
    beat = 0; stalled = 0; cyc = 0;
    while (beat < NB && cyc < 50) begin
      out_ready = !(beat == stall_beat && stalled < stall_len);
      if (!out_ready) stalled++;
      if (beat == 0) first_beat = out_mants;
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_idx"},   64'(out_idx),   64'(beat * P));
      chk({tag, "_mants"}, 64'(out_mants), 64'(ref_beat(vec, ie, beat)));
      chk({tag, "_exp"},   64'(out_exp),   64'(ie));
      chk({tag, "_nodone"}, 64'(done),     64'd0);
      @(negedge clk);
      if (out_ready) beat++;
      cyc++;
    end
    out_ready = 1'b1;
    chk({tag, "_done"},      64'(done),      64'd1);
    chk({tag, "_done_nov"},  64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_done_once"}, 64'(done),      64'd0);
  endtask

  function automatic logic [V*BIT-1:0] rand_vec(input int ie);
    logic [V*BIT-1:0] v;
    for (int i = 0; i < V; i++) begin
      if ($urandom_range(0, 7) == 0) v[i*BIT +: BIT] = mk(1'($urandom), -127, 0);
      else v[i*BIT +: BIT] = mk(1'($urandom), ie - int'($urandom_range(0, 18)),
                                int'($urandom_range(0, (1 << FPM) - 1)));
    end
    return v;
  endfunction

  initial begin
    logic [V*BIT-1:0] vec;
    int ie;
    reset = 1'b1; invect = '0; inExp = '0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mants", 64'(out_mants), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_exp", 64'(out_exp), 64'd0);
    chk("rst_err", 64'(align_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < V; i++) vec[i*BIT +: BIT] = mk(1'b0, 3, 0);
    run_vec("A", vec, 8'd3, -1, 0, 1'b1);
    chk("A_const", 64'(first_beat), 64'h4000_4000_4000_4000);

    for (int i = 0; i < V; i++) vec[i*BIT +: BIT] = mk(1'b0, 3, 0);
    vec[0*BIT +: BIT] = mk(1'b0, 1, 0);
    vec[1*BIT +: BIT] = mk(1'b1, 3, 0);
    vec[2*BIT +: BIT] = mk(1'b0, -20, 0);
    run_vec("B", vec, 8'd3, -1, 0, 1'b1);
    chk("B_l0", 64'(first_beat[15:0]),  64'h1000);
    chk("B_l1", 64'(first_beat[31:16]), 64'hC000);
    chk("B_l2", 64'(first_beat[47:32]), 64'h0000);

    run_vec("STALL", rand_vec(5), 8'd5, 1, 3, 1'b1);

    for (int i = 0; i < V; i++) vec[i*BIT +: BIT] = mk(1'b0, -127, 0);
    vec[0*BIT +: BIT] = mk(1'b0, 2, 'h200);
    run_vec("RND", vec, 8'd3, -1, 0, 1'b1);
`ifdef BFP_MANT_ALIGN_ROUND_EN
    chk("RND_l0", 64'(first_beat[15:0]), 64'h2001);
`else
    chk("RND_l0", 64'(first_beat[15:0]), 64'h2000);
`endif
    chk("no_err_yet", 64'(align_err), 64'd0);

    run_vec("HOLD", rand_vec(0), 8'd0, -1, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("hold_no_ready", 64'(in_ready), 64'd0);
      chk("hold_no_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    run_vec("REARM", rand_vec(12), 8'd12, -1, 0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      ie = int'($urandom_range(0, 40)) - 10;
      run_vec("RAND", rand_vec(ie), EW'(ie), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), 1'b1);
    end
    chk("rand_no_err", 64'(align_err), 64'd0);

    for (int i = 0; i < V; i++) vec[i*BIT +: BIT] = mk(1'b0, 3, 0);
    vec[0*BIT +: BIT] = mk(1'b0, 5, 0);
    run_vec("ERR", vec, 8'd3, -1, 0, 1'b1);
    chk("ERR_l0", 64'(first_beat[15:0]), 64'h4000);
    chk("ERR_set", 64'(align_err), 64'd1);
    run_vec("ERR2", rand_vec(4), 8'd4, -1, 0, 1'b1);
    chk("ERR_sticky", 64'(align_err), 64'd1);

    // Reset in the middle of streaming.
    vec = rand_vec(6);
    while (!in_ready) @(negedge clk);
    invect = vec; inExp = 8'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("MID_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("MID_rst_valid", 64'(out_valid), 64'd0);
    chk("MID_rst_done", 64'(done), 64'd0);
    chk("MID_rst_mants", 64'(out_mants), 64'd0);
    chk("MID_rst_ready", 64'(in_ready), 64'd0);
    chk("MID_rst_err", 64'(align_err), 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("MID_rearm", 64'(in_ready), 64'd1);
    chk("MID_idle_valid", 64'(out_valid), 64'd0);
    chk("MID_idle_done", 64'(done), 64'd0);
    run_vec("AFTER", rand_vec(2), 8'd2, -1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
